// File: rtl/alu_fun_encoder.sv
// Arbitrates four unit-class requests and encodes the winner into ALU_FUN, holding it for LAT cycles.
// Round-robin by default; defining ALU_ENC_FIXED_PRIO_EN selects fixed priority Arith > Logic > CMP > SHIFT.
module alu_fun_encoder #(
   parameter int LAT = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Arith_Req,
   input  logic       Logic_Req,
   input  logic       CMP_Req,
   input  logic       SHIFT_Req,
   output logic       Arith_Gnt,
   output logic       Logic_Gnt,
   output logic       CMP_Gnt,
   output logic       SHIFT_Gnt,
   output logic [1:0] ALU_FUN,
   output logic       ALU_Valid,
   output logic       OUT_VALID,
   output logic       Busy
);

   generate
      if (LAT < 1 || LAT > 16) begin : g_lat_range
         $error("alu_fun_encoder: LAT must be within 1..16");
      end
   endgenerate

   localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic [3:0] r_gnt;
   logic [3:0] w_gnt_nxt;
   logic [1:0] r_fun;
   logic [1:0] w_fun_nxt;
   logic       r_vld;
   logic       w_vld_nxt;
   logic       r_ov;
   logic       w_ov_nxt;
   logic       r_busy;
   logic       w_busy_nxt;

   logic [3:0] w_req;
   logic [1:0] w_win;
   logic       w_win_vld;

   // Bit index of w_req matches the ALU_FUN code of that unit class.
   assign w_req = {SHIFT_Req, CMP_Req, Logic_Req, Arith_Req};

`ifdef ALU_ENC_FIXED_PRIO_EN
   always_comb begin
      w_win_vld = |w_req;
      w_win     = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_req[i]) begin
            w_win = 2'(i);
         end
      end
   end
`else
   logic [1:0] r_ptr;
   logic [1:0] w_ptr_nxt;
   logic [1:0] w_idx;

   // Walk from the farthest offset back to PTR so the nearest requester wins.
   always_comb begin
      w_win_vld = |w_req;
      w_win     = r_ptr;
      w_idx     = r_ptr;
      for (int i = 3; i >= 0; i--) begin
         w_idx = r_ptr + 2'(i);
         if (w_req[w_idx]) begin
            w_win = w_idx;
         end
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gnt_nxt   = 4'b0000;
      w_fun_nxt   = r_fun;
      w_vld_nxt   = r_vld;
      w_ov_nxt    = 1'b0;
`ifndef ALU_ENC_FIXED_PRIO_EN
      w_ptr_nxt   = r_ptr;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_win_vld) begin
               w_state_nxt = S_ISSUE;
               w_fun_nxt   = w_win;
               w_vld_nxt   = 1'b1;
               w_gnt_nxt   = 4'b0001 << w_win;
               w_cnt_nxt   = LAT_M1;
`ifndef ALU_ENC_FIXED_PRIO_EN
               w_ptr_nxt   = w_win + 2'd1;
`endif
            end
         end
         S_ISSUE: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_DONE;
               w_vld_nxt   = 1'b0;
               w_ov_nxt    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_vld_nxt   = 1'b0;
         end
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_gnt   <= 4'b0000;
         r_fun   <= 2'b00;
         r_vld   <= 1'b0;
         r_ov    <= 1'b0;
         r_busy  <= 1'b0;
`ifndef ALU_ENC_FIXED_PRIO_EN
         r_ptr   <= 2'b00;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gnt   <= w_gnt_nxt;
         r_fun   <= w_fun_nxt;
         r_vld   <= w_vld_nxt;
         r_ov    <= w_ov_nxt;
         r_busy  <= w_busy_nxt;
`ifndef ALU_ENC_FIXED_PRIO_EN
         r_ptr   <= w_ptr_nxt;
`endif
      end
   end

   assign Arith_Gnt = r_gnt[0];
   assign Logic_Gnt = r_gnt[1];
   assign CMP_Gnt   = r_gnt[2];
   assign SHIFT_Gnt = r_gnt[3];
   assign ALU_FUN   = r_fun;
   assign ALU_Valid = r_vld;
   assign OUT_VALID = r_ov;
   assign Busy      = r_busy;

endmodule

// File: tb/tb_alu_fun_encoder.sv
// Directed bench for alu_fun_encoder: one instance with LAT=3, one with LAT=4 for the mid-operation reset case.
module tb_alu_fun_encoder;

   localparam int LAT3 = 3;
   localparam int LAT4 = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] reqs = 4'b0000;

   logic [3:0] gnt3, gnt4;
   logic [1:0] fun3, fun4;
   logic       vld3, vld4, ov3, ov4, busy3, busy4;
   logic [8:0] obs3, obs4;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int last_gnt_cyc = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_fun_encoder #(.LAT(LAT3)) u_dut3 (
      .CLK(clk), .RST(rst_n),
      .Arith_Req(reqs[0]), .Logic_Req(reqs[1]), .CMP_Req(reqs[2]), .SHIFT_Req(reqs[3]),
      .Arith_Gnt(gnt3[0]), .Logic_Gnt(gnt3[1]), .CMP_Gnt(gnt3[2]), .SHIFT_Gnt(gnt3[3]),
      .ALU_FUN(fun3), .ALU_Valid(vld3), .OUT_VALID(ov3), .Busy(busy3)
   );

   alu_fun_encoder #(.LAT(LAT4)) u_dut4 (
      .CLK(clk), .RST(rst_n),
      .Arith_Req(reqs[0]), .Logic_Req(reqs[1]), .CMP_Req(reqs[2]), .SHIFT_Req(reqs[3]),
      .Arith_Gnt(gnt4[0]), .Logic_Gnt(gnt4[1]), .CMP_Gnt(gnt4[2]), .SHIFT_Gnt(gnt4[3]),
      .ALU_FUN(fun4), .ALU_Valid(vld4), .OUT_VALID(ov4), .Busy(busy4)
   );

   // Observation word: {Busy, OUT_VALID, ALU_Valid, ALU_FUN[1:0], SHIFT/CMP/Logic/Arith grants}
   assign obs3 = {busy3, ov3, vld3, fun3, gnt3};
   assign obs4 = {busy4, ov4, vld4, fun4, gnt4};

   function automatic logic [8:0] mk(input logic busy, input logic ov, input logic vld,
                                     input logic [1:0] fun, input logic [3:0] gnt);
      return {busy, ov, vld, fun, gnt};
   endfunction

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      reqs  = 4'b0000;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Requests must already be presented; observes one complete operation on u_dut3.
   task automatic run_op(input string tag, input logic [1:0] code, input bit drop);
      logic [3:0] oh;
      oh = 4'b0001 << code;
      step();
      chk({tag, "_gnt"}, 16'(obs3), 16'(mk(1'b1, 1'b0, 1'b1, code, oh)));
      if (last_gnt_cyc >= 0) begin
         chk({tag, "_spacing"}, 16'(cyc - last_gnt_cyc), 16'(LAT3 + 2));
      end
      last_gnt_cyc = cyc;
      if (drop) reqs[code] = 1'b0;
      for (int i = 1; i < LAT3; i++) begin
         step();
         chk($sformatf("%s_hold%0d", tag, i), 16'(obs3), 16'(mk(1'b1, 1'b0, 1'b1, code, 4'b0000)));
      end
      step();
      chk({tag, "_done"}, 16'(obs3), 16'(mk(1'b1, 1'b1, 1'b0, code, 4'b0000)));
      step();
      chk({tag, "_idle"}, 16'(obs3), 16'(mk(1'b0, 1'b0, 1'b0, code, 4'b0000)));
   endtask

   logic [1:0] exp_seq [5];

   initial begin
      // Reset with no requests
      do_reset();
      chk("rst_obs3", 16'(obs3), 16'h0000);
      chk("rst_obs4", 16'(obs4), 16'h0000);
      step();
      chk("rst_idle3", 16'(obs3), 16'h0000);
      step();
      chk("rst_idle3b", 16'(obs3), 16'h0000);

      // Single CMP request, dropped once granted
      reqs = 4'b0100;
      run_op("cmp", 2'b10, 1'b1);
      step();
      chk("cmp_quiet", 16'(obs3), 16'(mk(1'b0, 1'b0, 1'b0, 2'b10, 4'b0000)));

      // All four held: round-robin order, or Arith forever under fixed priority
      do_reset();
      last_gnt_cyc = -1;
`ifdef ALU_ENC_FIXED_PRIO_EN
      exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
      reqs = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         run_op($sformatf("rr%0d", k), exp_seq[k], 1'b0);
      end
      reqs = 4'b0000;
      last_gnt_cyc = -1;

      // Wrap-around: SHIFT first, then Arith+CMP together
      do_reset();
      reqs = 4'b1000;
      run_op("wrap_shift", 2'b11, 1'b1);
      reqs = 4'b0101;
      run_op("wrap_arith", 2'b00, 1'b1);
      run_op("wrap_cmp", 2'b10, 1'b1);
      last_gnt_cyc = -1;

      // Reset in the second ALU_Valid cycle of a LAT=4 operation
      do_reset();
      reqs = 4'b0001;
      step();
      chk("mid_gnt4", 16'(obs4), 16'(mk(1'b1, 1'b0, 1'b1, 2'b00, 4'b0001)));
      reqs = 4'b0000;
      step();
      chk("mid_vld2", 16'(obs4), 16'(mk(1'b1, 1'b0, 1'b1, 2'b00, 4'b0000)));
      rst_n = 1'b0;
      step();
      chk("mid_abort4", 16'(obs4), 16'h0000);
      chk("mid_abort3", 16'(obs3), 16'h0000);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("mid_after%0d", i), 16'(obs4), 16'h0000);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
